rr_arb: RTL and testbench
=========================

# rr_arb

Round-robin arbiter that shares one DTI output stream between `SIZE` DTI input streams, with zero-latency combinational forwarding. It is the many-to-one counterpart of the broadcast block. It sits wherever several producers must be sequenced onto a single consumer. Multi-beat transactions, delimited by an end-of-transaction (eot) bit, are never interleaved. The winning input index is appended to the output data so downstream logic can demultiplex.

## Interface
- `SIZE`, default 2: number of input streams, minimum 1.
- `DIN_W`, default 16: width of each `din[i].data`.
- `EOT_BIT`, default `DIN_W-1`: bit position in `din[i].data` marking the last beat of a transaction.
- `LOCK`, default 1: 1 keeps the grant until a beat with eot=1 transfers; 0 re-arbitrates after every beat.
- `IDX_W` (derived): `$clog2(SIZE)`, forced to 1 when `SIZE`=1.
- Clocking and reset (decided): reset `rst`, synchronous, active-high; clock `clk`.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous active-high reset.
- `din[SIZE-1:0]`, `dti.consumer`, data `DIN_W`: requester streams.
- `dout`, `dti.producer`, data `IDX_W+DIN_W`: arbitrated stream, `{idx, din[idx].data}`.

## Operation
- Registers:
  - `state` ∈ {IDLE, HOLD, LOCKED}.
  - `ptr` [IDX_W]: highest-priority index.
  - `cur` [IDX_W]: frozen grant.
- IDLE:
  - `sel` = first i with `din[i].valid`, scanning `ptr`, `ptr+1`, …, wrapping modulo `SIZE`.
  - `dout.valid` = OR of all `din[i].valid`.
- HOLD and LOCKED: `sel` = `cur`, and `dout.valid` = `din[cur].valid`.
- Routing:
  - `dout.data` = `{sel, din[sel].data}`.
  - `din[i].ready` = `dout.ready & dout.valid & (i == sel)`.
  - All other inputs have `ready` = 0.
- A handshake (hs) is `dout.valid & dout.ready`.
- `eot` = `din[sel].data[EOT_BIT]`, or constant 1 when `LOCK`=0.
- Transitions:
  - IDLE, valid without hs → HOLD, `cur`←`sel`. This freezes the offered beat so a new higher-priority request cannot change `dout.data` while stalled.
  - IDLE or HOLD, hs with eot=1 → IDLE, `ptr`←(`sel`+1) mod `SIZE`.
  - IDLE or HOLD, hs with eot=0 → LOCKED, `cur`←`sel`.
  - LOCKED, hs with eot=1 → IDLE, `ptr`←(`cur`+1) mod `SIZE`.
  - LOCKED, otherwise → stay in LOCKED. Valid gaps from `din[cur]` do not release the lock.
- Wrap-around: the increment from `SIZE-1` goes to 0. It is also correct for non-power-of-two `SIZE`.
- `SIZE`=1: behaves as a pass-through with idx=0. The lock logic is still active and harmless.
- Reset:
  - `state`=IDLE, `ptr`=0, `cur`=0.
  - While `rst`=1, `dout.valid`=0 and all `din[i].ready`=0.
  - Reset mid-transaction drops the lock immediately. The next cycle arbitrates from index 0.

## Timing
- Latency is 0 cycles. `din` valid/data reach `dout` combinationally, and `dout.ready` reaches `din[sel].ready` combinationally.
- Throughput is one beat per cycle with no bubbles between different inputs: a grant change takes effect in the cycle after the eot handshake.
- DTI rules:
  - Once `dout.valid`=1, `dout.data` and `idx` are stable until hs. This is guaranteed by HOLD and LOCKED.
  - `dout.valid` never depends combinationally on `dout.ready`.
- Fairness:
  - When all inputs request continuously with single-beat transactions, the grant order is 0, 1, …, `SIZE-1`, 0, …
  - Worst-case wait is `SIZE-1` transactions.
- Simultaneous events:
  - eot hs plus new requests: the new grant is computed from the updated `ptr` on the next cycle.
  - A request from the just-served input has lowest priority next cycle.

## Test plan
- Reset: hold `rst` 2 cycles with all `din` valid → `dout.valid`=0 and all ready=0 during reset. First grant after reset goes to index 0.
- Round-robin, `SIZE`=4, all inputs valid, single beats (eot=1), `dout.ready`=1 → idx sequence 0,1,2,3,0,1 on consecutive cycles, one beat per cycle.
- Lock: `din[1]` sends 3 beats (eot on the third) while `din[0]` and `din[2]` stay valid → idx 1,1,1 then 2 then 0, with no interleave. A valid gap on `din[1]` between beats keeps the lock.
- Stall stability: in IDLE, `din[2]` valid with `dout.ready`=0, then `din[0]` (higher priority) asserts → `dout.data` and idx stay on 2 until ready. After that, idx=0 is next.
- `LOCK`=0 with the eot bit clear on all beats → re-arbitration every beat, sequence 0,1,0,1 for two requesters.
- Reset mid-lock: `rst` asserted after beat 1 of a 3-beat transaction on `din[3]` → after reset, `din[1]` and `din[3]` are both valid and idx=1 wins (`ptr`=0).

Source files
------------

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter merging SIZE valid/ready streams onto one output.
// The output path is purely combinational; a small FSM freezes the grant while
// a beat is stalled (HOLD) or a multi-beat transaction is in flight (LOCKED).
// The winning index is prepended to the forwarded data for demultiplexing.
module rr_arb #(
    parameter int SIZE    = 2,
    parameter int DIN_W   = 16,
    parameter int EOT_BIT = DIN_W - 1,
    parameter int LOCK    = 1,
    parameter int IDX_W   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [SIZE-1:0]              din_valid,
    input  logic [SIZE-1:0][DIN_W-1:0]   din_data,
    output logic [SIZE-1:0]              din_ready,
    output logic                         dout_valid,
    input  logic                         dout_ready,
    output logic [IDX_W+DIN_W-1:0]       dout_data
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   cur_q, cur_d;

    logic [IDX_W-1:0]   sel_idle;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   sel_next;
    logic [DIN_W-1:0]   sel_data;
    logic               valid_raw;
    logic               eot;
    logic               hs;

    // Rotating priority scan: first valid requester starting at ptr, wrapping at SIZE.
    always_comb begin
        int               cand;
        logic             found;
        logic [IDX_W-1:0] cand_idx;
        sel_idle = '0;
        found    = 1'b0;
        cand_idx = '0;
        for (int k = 0; k < SIZE; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= SIZE) begin
                cand = cand - SIZE;
            end
            cand_idx = IDX_W'(cand);
            if (!found && din_valid[cand_idx]) begin
                found    = 1'b1;
                sel_idle = cand_idx;
            end
        end
    end

    // Output routing: live arbitration in IDLE, frozen grant otherwise; reset masks handshakes.
    always_comb begin
        sel       = cur_q;
        valid_raw = din_valid[cur_q];
        if (state_q == IDLE) begin
            sel       = sel_idle;
            valid_raw = |din_valid;
        end
        sel_data   = din_data[sel];
        dout_valid = valid_raw & ~rst;
        dout_data  = {sel, sel_data};
        hs         = dout_valid & dout_ready;
        eot        = (LOCK != 0) ? sel_data[EOT_BIT] : 1'b1;
        sel_next   = (sel == IDX_W'(SIZE - 1)) ? '0 : sel + 1'b1;
        din_ready      = '0;
        din_ready[sel] = dout_ready & dout_valid;
    end

    // Next-state logic: freeze on stall, lock on non-final beat, advance pointer on eot.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE, HOLD: begin
                if (hs) begin
                    if (eot) begin
                        state_d = IDLE;
                        ptr_d   = sel_next;
                    end else begin
                        state_d = LOCKED;
                        cur_d   = sel;
                    end
                end else if (dout_valid && state_q == IDLE) begin
                    state_d = HOLD;
                    cur_d   = sel;
                end
            end
            LOCKED: begin
                if (hs && eot) begin
                    state_d = IDLE;
                    ptr_d   = sel_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset drops any lock and restarts at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cur_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
        end
    end

endmodule

// File: tb/tb_rr_arb.sv
// tb_rr_arb: directed tests for rr_arb. DUT a is a 4-input locking arbiter,
// DUT b a 2-input arbiter with per-beat re-arbitration. Inputs change just after
// the falling edge and outputs are checked 1ns later, well away from the rising edge.
module tb_rr_arb;

    logic clk;
    logic rst;

    logic [3:0]        a_valid;
    logic [3:0][7:0]   a_data;
    logic [3:0]        a_ready;
    logic              a_dout_valid;
    logic              a_dout_ready;
    logic [9:0]        a_dout_data;

    logic [1:0]        b_valid;
    logic [1:0][7:0]   b_data;
    logic [1:0]        b_ready;
    logic              b_dout_valid;
    logic              b_dout_ready;
    logic [8:0]        b_dout_data;

    int vectors;
    int miscompares;

    rr_arb #(.SIZE(4), .DIN_W(8), .EOT_BIT(7), .LOCK(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (a_valid),
        .din_data   (a_data),
        .din_ready  (a_ready),
        .dout_valid (a_dout_valid),
        .dout_ready (a_dout_ready),
        .dout_data  (a_dout_data)
    );

    rr_arb #(.SIZE(2), .DIN_W(8), .EOT_BIT(7), .LOCK(0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (b_valid),
        .din_data   (b_data),
        .din_ready  (b_ready),
        .dout_valid (b_dout_valid),
        .dout_ready (b_dout_ready),
        .dout_data  (b_dout_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mk(input logic e, input int src, input int beat);
        return {e, 3'(src), 4'(beat)};
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst          = 1'b1;
        a_valid      = '0;
        b_valid      = '0;
        a_dout_ready = 1'b1;
        b_dout_ready = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        step();
        rst          = 1'b1;
        a_dout_ready = 1'b1;
        a_valid      = 4'b1111;
        for (int i = 0; i < 4; i++) a_data[i] = mk(1'b1, i, 0);
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++;
            if (a_dout_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL reset_valid cyc%0d: got %b expected 0", c, a_dout_valid);
            end
            vectors++;
            if (a_ready !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL reset_ready cyc%0d: got %b expected 0000", c, a_ready);
            end
            step();
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (a_dout_valid !== 1'b1 || a_dout_data !== {2'd0, mk(1'b1, 0, 0)}) begin
            miscompares++;
            $display("[TB] FAIL reset_first_grant: got v=%b d=%h expected v=1 d=%h",
                     a_dout_valid, a_dout_data, {2'd0, mk(1'b1, 0, 0)});
        end
        vectors++;
        if (a_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL reset_first_ready: got %b expected 0001", a_ready);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx;
        do_reset();
        a_valid = 4'b1111;
        for (int i = 0; i < 4; i++) a_data[i] = mk(1'b1, i, 1);
        for (int c = 0; c < 6; c++) begin
            exp_idx = 2'(c % 4);
            #1;
            vectors++;
            if (a_dout_valid !== 1'b1 || a_dout_data !== {exp_idx, mk(1'b1, int'(exp_idx), 1)}
                || a_ready !== (4'b0001 << exp_idx)) begin
                miscompares++;
                $display("[TB] FAIL rr_seq cyc%0d: got v=%b d=%h r=%b expected idx %0d",
                         c, a_dout_valid, a_dout_data, a_ready, exp_idx);
            end
            step();
        end
    endtask

    task automatic test_lock();
        do_reset();
        a_valid = 4'b0001;
        a_data[0] = mk(1'b1, 0, 0);
        #1;
        vectors++;
        if (a_dout_data !== {2'd0, mk(1'b1, 0, 0)}) begin
            miscompares++;
            $display("[TB] FAIL lock_pre: got %h expected %h", a_dout_data, {2'd0, mk(1'b1, 0, 0)});
        end
        step();
        a_valid   = 4'b0111;
        a_data[0] = mk(1'b1, 0, 1);
        a_data[2] = mk(1'b1, 2, 1);
        a_data[1] = mk(1'b0, 1, 1);
        #1;
        vectors++;
        if (a_dout_data !== {2'd1, mk(1'b0, 1, 1)} || a_ready !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL lock_beat1: got d=%h r=%b expected d=%h r=0010",
                     a_dout_data, a_ready, {2'd1, mk(1'b0, 1, 1)});
        end
        step();
        a_valid = 4'b0101;
        #1;
        vectors++;
        if (a_dout_valid !== 1'b0 || a_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL lock_gap: got v=%b r=%b expected v=0 r=0000", a_dout_valid, a_ready);
        end
        step();
        a_valid   = 4'b0111;
        a_data[1] = mk(1'b0, 1, 2);
        #1;
        vectors++;
        if (a_dout_valid !== 1'b1 || a_dout_data !== {2'd1, mk(1'b0, 1, 2)}) begin
            miscompares++;
            $display("[TB] FAIL lock_beat2: got v=%b d=%h expected v=1 d=%h",
                     a_dout_valid, a_dout_data, {2'd1, mk(1'b0, 1, 2)});
        end
        step();
        a_data[1] = mk(1'b1, 1, 3);
        #1;
        vectors++;
        if (a_dout_data !== {2'd1, mk(1'b1, 1, 3)} || a_ready !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL lock_beat3: got d=%h r=%b expected d=%h r=0010",
                     a_dout_data, a_ready, {2'd1, mk(1'b1, 1, 3)});
        end
        step();
        a_valid = 4'b0101;
        #1;
        vectors++;
        if (a_dout_data !== {2'd2, mk(1'b1, 2, 1)} || a_ready !== 4'b0100) begin
            miscompares++;
            $display("[TB] FAIL lock_after_a: got d=%h r=%b expected d=%h r=0100",
                     a_dout_data, a_ready, {2'd2, mk(1'b1, 2, 1)});
        end
        step();
        #1;
        vectors++;
        if (a_dout_data !== {2'd0, mk(1'b1, 0, 1)} || a_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL lock_after_b: got d=%h r=%b expected d=%h r=0001",
                     a_dout_data, a_ready, {2'd0, mk(1'b1, 0, 1)});
        end
    endtask

    task automatic test_stall();
        do_reset();
        a_dout_ready = 1'b0;
        a_valid      = 4'b0100;
        a_data[2]    = mk(1'b1, 2, 5);
        a_data[0]    = mk(1'b1, 0, 5);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) a_valid = 4'b0101;
            if (c == 2) a_dout_ready = 1'b1;
            #1;
            vectors++;
            if (a_dout_valid !== 1'b1 || a_dout_data !== {2'd2, mk(1'b1, 2, 5)}
                || a_ready !== (c == 2 ? 4'b0100 : 4'b0000)) begin
                miscompares++;
                $display("[TB] FAIL stall_hold cyc%0d: got v=%b d=%h r=%b expected d=%h",
                         c, a_dout_valid, a_dout_data, a_ready, {2'd2, mk(1'b1, 2, 5)});
            end
            step();
        end
        a_valid = 4'b0001;
        #1;
        vectors++;
        if (a_dout_data !== {2'd0, mk(1'b1, 0, 5)} || a_ready !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL stall_next: got d=%h r=%b expected d=%h r=0001",
                     a_dout_data, a_ready, {2'd0, mk(1'b1, 0, 5)});
        end
    endtask

    task automatic test_no_lock();
        logic exp_idx;
        do_reset();
        b_valid   = 2'b11;
        b_data[0] = mk(1'b0, 0, 7);
        b_data[1] = mk(1'b0, 1, 7);
        for (int c = 0; c < 4; c++) begin
            exp_idx = 1'(c % 2);
            #1;
            vectors++;
            if (b_dout_valid !== 1'b1 || b_dout_data !== {exp_idx, mk(1'b0, int'(exp_idx), 7)}
                || b_ready !== (2'b01 << exp_idx)) begin
                miscompares++;
                $display("[TB] FAIL nolock_seq cyc%0d: got v=%b d=%h r=%b expected idx %0d",
                         c, b_dout_valid, b_dout_data, b_ready, exp_idx);
            end
            step();
        end
        b_valid = 2'b00;
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        a_valid   = 4'b1000;
        a_data[3] = mk(1'b0, 3, 1);
        #1;
        vectors++;
        if (a_dout_data !== {2'd3, mk(1'b0, 3, 1)} || a_ready !== 4'b1000) begin
            miscompares++;
            $display("[TB] FAIL midlock_beat1: got d=%h r=%b expected d=%h r=1000",
                     a_dout_data, a_ready, {2'd3, mk(1'b0, 3, 1)});
        end
        step();
        rst       = 1'b1;
        a_data[3] = mk(1'b0, 3, 2);
        #1;
        vectors++;
        if (a_dout_valid !== 1'b0 || a_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL midlock_in_reset: got v=%b r=%b expected v=0 r=0000",
                     a_dout_valid, a_ready);
        end
        step();
        rst       = 1'b0;
        a_valid   = 4'b1010;
        a_data[1] = mk(1'b1, 1, 1);
        #1;
        vectors++;
        if (a_dout_data !== {2'd1, mk(1'b1, 1, 1)} || a_ready !== 4'b0010) begin
            miscompares++;
            $display("[TB] FAIL midlock_after: got d=%h r=%b expected d=%h r=0010",
                     a_dout_data, a_ready, {2'd1, mk(1'b1, 1, 1)});
        end
    endtask

    // Run every scenario in order, then report totals.
    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        a_valid      = '0;
        a_data       = '0;
        a_dout_ready = 1'b0;
        b_valid      = '0;
        b_data       = '0;
        b_dout_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_lock();
        test_stall();
        test_no_lock();
        test_reset_mid_lock();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
